window_gen: RTL and testbench

//  Converts a raster pixel stream (one pixel per beat, carried in data[1][1])

---
 rtl/pixel_pkg.sv | 15 +
 rtl/axis_if.sv | 14 +
 rtl/line_buffer.sv | 24 ++
 rtl/window_gen.sv | 93 +++++++++
 tb/tb_window_gen.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel and window types for the raster filter chain.
package pixel_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef pixel_t window_t [3][3];

endpackage

// File: rtl/axis_if.sv
// Window-carrying valid/ready stream; ok marks a transfer in the current cycle.
interface axis_if;
  import pixel_pkg::*;

  window_t data;
  logic    vld;
  logic    rdy;
  logic    ok;

  assign ok = vld && rdy;

  modport master (output data, output vld, input rdy, input ok);
  modport slave  (input data, input vld, output rdy, input ok);
endinterface

// File: rtl/line_buffer.sv
// One raster line of pixels: synchronous write, asynchronous read at the same column.
module line_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read returns the value stored before this cycle's write.
  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen.sv
// Turns a one-pixel-per-beat raster stream into fully populated 3x3 windows.
module window_gen
  import pixel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic     clk,
  input  logic     rst,
  axis_if.slave    axis_i,
  axis_if.master   axis_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  window_t          win_p0;
  window_t          win_nxt;
  pixel_t           pix;
  pixel_t           lb0_q;
  pixel_t           lb1_q;
  logic             acc;
  logic             emit;

  assign axis_i.rdy = !axis_o.vld || axis_o.rdy;
  assign acc        = axis_i.ok;
  assign pix        = axis_i.data[1][1];
  // Row/col gates drop windows holding stale lines or straddling a line wrap.
  assign emit       = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  line_buffer #(.DEPTH(IMG_W), .AW(COL_W)) u_lb0 (
    .clk   (clk),
    .we    (acc),
    .addr  (col),
    .wdata (pix),
    .rdata (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (acc),
    .addr  (col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        win_nxt[i][j] = win_p0[i][j+1];
      end
    end
    win_nxt[0][2] = lb1_q;
    win_nxt[1][2] = lb0_q;
    win_nxt[2][2] = pix;
  end

  // Stage p0: window shift register and raster counters; output register follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      axis_o.vld <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_p0[i][j]      <= '0;
          axis_o.data[i][j] <= '0;
        end
      end
    end else begin
      if (acc) begin
        win_p0 <= win_nxt;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (acc && emit) begin
        axis_o.data <= win_nxt;
        axis_o.vld  <= 1'b1;
      end else if (axis_o.ok) begin
        axis_o.vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Randomized self-checking bench for window_gen on a 5x4 frame.
module tb_window_gen;
  import pixel_pkg::*;

  localparam int W = 5;
  localparam int H = 4;
  localparam int NWIN = (W - 2) * (H - 2);
  typedef logic [9*24-1:0] flat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  flat_t got[$];
  flat_t exp_q[$];

  axis_if axis_i ();
  axis_if axis_o ();

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .rst    (rst),
    .axis_i (axis_i),
    .axis_o (axis_o)
  );

  always #5 clk = ~clk;

  function automatic pixel_t pix(input int r, input int c);
    logic [7:0] v;
    v = 8'(16 * r + c);
    return '{r: v, g: v, b: v};
  endfunction

  function automatic flat_t flat(input window_t w);
    flat_t f;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        f[(i*3+j)*24 +: 24] = w[i][j];
    return f;
  endfunction

  // Reference: every window centred on (r,c) with 1<=r<=H-2, 1<=c<=W-2, raster order.
  function automatic flat_t model_win(input int cr, input int cc);
    window_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = pix(cr - 1 + i, cc - 1 + j);
    return flat(w);
  endfunction

  task automatic build_expected(input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      for (int r = 1; r <= H - 2; r++)
        for (int c = 1; c <= W - 2; c++)
          exp_q.push_back(model_win(r, c));
  endtask

  always @(negedge clk) begin
    if (axis_o.vld && axis_o.rdy) got.push_back(flat(axis_o.data));
  end

  task automatic send_px(input int r, input int c);
    int   t;
    logic accepted;
    t = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        axis_i.data[i][j] = pixel_t'(24'($urandom));
    axis_i.data[1][1] = pix(r, c);
    axis_i.vld = 1'b1;
    forever begin
      @(negedge clk);
      accepted = axis_i.rdy;
      @(posedge clk);
      #1;
      if (accepted) break;
      t++;
      if (t > 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout px(%0d,%0d) not accepted, required acceptance within 2000 cycles", r, c);
        break;
      end
    end
    axis_i.vld = 1'b0;
  endtask

  task automatic maybe_gap(input int enable);
    if (enable != 0 && $urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        maybe_gap(gaps);
        send_px(r, c);
      end
  endtask

  task automatic drain();
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    axis_i.vld = 1'b0;
    axis_o.rdy = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (axis_o.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", axis_o.vld); end
    checks++;
    if (flat(axis_o.data) !== '0) begin errors++; $display("FAIL reset_data got %h want 0", flat(axis_o.data)); end
    checks++;
    if (axis_i.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", axis_i.rdy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    got.delete();
    build_expected(1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send_px(r, c);
        if (r == 2 && c == 2) begin
          checks++;
          if (axis_o.vld !== 1'b1 || flat(axis_o.data) !== exp_q[0]) begin
            errors++;
            $display("FAIL stream_latency vld=%b data=%h want vld=1 data=%h", axis_o.vld, flat(axis_o.data), exp_q[0]);
          end
        end
      end
    drain();
    checks++;
    if (got.size() != NWIN) begin errors++; $display("FAIL stream_count got %0d want %0d", got.size(), NWIN); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL stream_win%0d got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_gaps();
    got.delete();
    build_expected(1);
    send_frame(1);
    drain();
    checks++;
    if (got.size() != NWIN) begin errors++; $display("FAIL gaps_count got %0d want %0d", got.size(), NWIN); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL gaps_win%0d got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    flat_t d0;
    int    t;
    got.delete();
    build_expected(1);
    axis_o.rdy = 1'b0;
    fork
      send_frame(1);
      begin
        t = 0;
        while (axis_o.vld !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (axis_o.vld !== 1'b1) begin errors++; $display("FAIL stall_wait vld=%b want 1 within 200 cycles", axis_o.vld); end
        @(negedge clk);
        d0 = flat(axis_o.data);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (axis_i.rdy !== 1'b0 || axis_o.vld !== 1'b1 || flat(axis_o.data) !== d0) begin
            errors++;
            $display("FAIL stall_hold%0d in_rdy=%b vld=%b data=%h want rdy=0 vld=1 data=%h",
                     k, axis_i.rdy, axis_o.vld, flat(axis_o.data), d0);
          end
        end
        checks++;
        if (d0 !== exp_q[0]) begin errors++; $display("FAIL stall_first got %h want %h", d0, exp_q[0]); end
        @(posedge clk); #1;
        axis_o.rdy = 1'b1;
      end
    join
    drain();
    checks++;
    if (got.size() != NWIN) begin errors++; $display("FAIL stall_count got %0d want %0d", got.size(), NWIN); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL stall_win%0d got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    got.delete();
    build_expected(2);
    send_frame(0);
    send_frame(0);
    drain();
    checks++;
    if (got.size() != 2 * NWIN) begin errors++; $display("FAIL b2b_count got %0d want %0d", got.size(), 2 * NWIN); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_win%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    if (got.size() > NWIN) begin
      checks++;
      if (got[NWIN][4*24 +: 8] !== 8'h11) begin
        errors++; $display("FAIL b2b_centre got %h want 11", got[NWIN][4*24 +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 13; k++) send_px(k / W, k % W);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (axis_o.vld !== 1'b0) begin errors++; $display("FAIL midrst_async_vld got %b want 0", axis_o.vld); end
    @(negedge clk);
    checks++;
    if (axis_o.vld !== 1'b0) begin errors++; $display("FAIL midrst_hold_vld got %b want 0", axis_o.vld); end
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    build_expected(1);
    send_frame(1);
    drain();
    checks++;
    if (got.size() != NWIN) begin errors++; $display("FAIL midrst_count got %0d want %0d", got.size(), NWIN); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_win%0d got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_line_wrap();
    bit done;
    int bad;
    got.delete();
    done = 1'b0;
    fork
      begin send_frame(1); done = 1'b1; end
      while (!done) begin @(posedge clk); #1; axis_o.rdy = 1'($urandom_range(0, 1)); end
    join
    axis_o.rdy = 1'b1;
    drain();
    checks++;
    if (got.size() != NWIN) begin errors++; $display("FAIL wrap_count got %0d want %0d", got.size(), NWIN); end
    for (int k = 0; k < got.size(); k++) begin
      bad = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 2; j++)
          if (int'(got[k][(i*3+j+1)*24 +: 4]) != int'(got[k][(i*3+j)*24 +: 4]) + 1) bad = 1;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL wrap_win%0d spans line boundary: %h", k, got[k]); end
    end
  endtask

  initial begin
    axis_i.vld = 1'b0;
    axis_o.rdy = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        axis_i.data[i][j] = '0;
    test_reset();
    test_stream();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_line_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
